// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM states, default parameters and bit-count clamp.
package uart_rx_pkg;

    localparam int unsigned OVERSAMPLE_DEF  = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned MIN_BITS        = 5;
    localparam int unsigned MAX_BITS        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Out-of-range data widths saturate to the nearest legal value.
    function automatic logic [3:0] clamp_bits(input logic [3:0] n);
        if (n < 4'(MIN_BITS)) return 4'(MIN_BITS);
        if (n > 4'(MAX_BITS)) return 4'(MAX_BITS);
        return n;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver pin/config inputs and parallel result outputs; master = host side, slave = receiver.
interface uart_rx_if;
    logic       i_exist_oddcheck;
    logic       i_exist_evencheck;
    logic       i_exist_stop;
    logic [3:0] i_bitnum;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;

    modport master (
        output i_exist_oddcheck, i_exist_evencheck, i_exist_stop, i_bitnum, i_rx,
        input  o_data, o_data_valid, o_parity_err, o_frame_err, o_busy
    );

    modport slave (
        input  i_exist_oddcheck, i_exist_evencheck, i_exist_stop, i_bitnum, i_rx,
        output o_data, o_data_valid, o_parity_err, o_frame_err, o_busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the async serial line plus falling-edge detect.
module uart_rx_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic [STAGES-1:0] chain;
    logic              rx_d;

    // Preset to 1 so reset looks like an idle line and never fakes a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
            rx_d  <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], rx};
            rx_d  <= chain[STAGES-1];
        end
    end

    assign rx_s    = chain[STAGES-1];
    assign rx_fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with parity/framing checks.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around each mid-bit point.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic     i_clkx16,
    input  logic     i_rst,
    uart_rx_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned HALF  = OVERSAMPLE / 2;

    logic             rx_s;
    logic             rx_fall;
    logic             bit_c;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bitcnt;
    logic [3:0]       nbits_q;
    logic             odd_q;
    logic             par_q;
    logic             stop_q;
    logic [7:0]       sh;
    logic             perr_q;
    logic             ferr_q;
    logic             fin;
    logic             last_tick;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (i_clkx16),
        .rst     (i_rst),
        .rx      (bus.i_rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Two previous ticks plus the current one give the three votes; decision point is unchanged.
    always_ff @(posedge i_clkx16) begin
        if (i_rst) hist <= 2'b11;
        else       hist <= {hist[0], rx_s};
    end

    assign bit_c = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_c = rx_s;
`endif

    assign last_tick = (cnt == CNT_W'(OVERSAMPLE - 1));

    always_ff @(posedge i_clkx16) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            bitcnt           <= '0;
            nbits_q          <= 4'(MIN_BITS);
            odd_q            <= 1'b0;
            par_q            <= 1'b0;
            stop_q           <= 1'b0;
            sh               <= '0;
            perr_q           <= 1'b0;
            ferr_q           <= 1'b0;
            fin              <= 1'b0;
            bus.o_data       <= '0;
            bus.o_data_valid <= 1'b0;
            bus.o_parity_err <= 1'b0;
            bus.o_frame_err  <= 1'b0;
            bus.o_busy       <= 1'b0;
        end else begin
            bus.o_data_valid <= 1'b0;
            cnt              <= cnt + CNT_W'(1);

            // Result is published one cycle after the final mid-bit sample.
            if (fin) begin
                fin              <= 1'b0;
                bus.o_data_valid <= 1'b1;
                bus.o_data       <= sh;
                bus.o_parity_err <= perr_q;
                bus.o_frame_err  <= ferr_q;
                bus.o_busy       <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        cnt     <= '0;
                        state   <= ST_START;
                        odd_q   <= bus.i_exist_oddcheck;
                        par_q   <= bus.i_exist_oddcheck | bus.i_exist_evencheck;
                        stop_q  <= bus.i_exist_stop;
                        nbits_q <= clamp_bits(bus.i_bitnum);
                    end
                end
                ST_START: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        if (bit_c) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt        <= '0;
                            state      <= ST_DATA;
                            bitcnt     <= '0;
                            sh         <= '0;
                            perr_q     <= 1'b0;
                            ferr_q     <= 1'b0;
                            bus.o_busy <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (last_tick) begin
                        sh[bitcnt[2:0]] <= bit_c;
                        bitcnt          <= bitcnt + 4'd1;
                        if (bitcnt == nbits_q - 4'd1) begin
                            if (par_q)       state <= ST_PARITY;
                            else if (stop_q) state <= ST_STOP;
                            else begin
                                state <= ST_IDLE;
                                fin   <= 1'b1;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (last_tick) begin
                        perr_q <= ((^sh) ^ bit_c) != odd_q;
                        if (stop_q) state <= ST_STOP;
                        else begin
                            state <= ST_IDLE;
                            fin   <= 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (last_tick) begin
                        ferr_q <= ~bit_c;
                        state  <= ST_IDLE;
                        fin    <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random frames against a frame-level scoreboard.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int unsigned OS = OVERSAMPLE_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    uart_rx_if bus();

    uart_rx dut (
        .i_clkx16 (clk),
        .i_rst    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes
    logic [7:0] q_data[$];
    bit         q_perr[$];
    bit         q_ferr[$];
    bit         q_busy[$];
    int         q_cyc[$];
    bit         busy_seen = 1'b0;

    // Expected strobes
    logic [7:0] e_data[$];
    bit         e_perr[$];
    bit         e_ferr[$];
    int         e_cyc[$];

    always @(negedge clk) begin
        if (bus.o_data_valid === 1'b1) begin
            q_data.push_back(bus.o_data);
            q_perr.push_back(bus.o_parity_err);
            q_ferr.push_back(bus.o_frame_err);
            q_busy.push_back(bus.o_busy);
            q_cyc.push_back(cyc);
        end
        if (bus.o_busy === 1'b1) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Builds the line waveform and the expected result from the frame rules, then drives it.
    task automatic send(input logic [7:0] d, input int nb, input bit odd, input bit even,
                        input bit stp, input bit flip, input bit stopbit, input int cut);
        int         n;
        int         ones;
        int         k;
        bit         pbit;
        bit         bits[$];
        logic [7:0] ed;
        bit         ep;
        bit         ef;
        n    = (nb < 5) ? 5 : ((nb > 8) ? 8 : nb);
        ed   = d & 8'((1 << n) - 1);
        ones = $countones(ed);
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) bits.push_back(d[i]);
        ep = 1'b0;
        if (odd || even) begin
            pbit = (odd ? ((ones % 2) == 0) : ((ones % 2) == 1)) ^ flip;
            bits.push_back(pbit);
            ep = ((ones + int'(pbit)) % 2) != (odd ? 1 : 0);
        end
        ef = 1'b0;
        if (stp) begin
            bits.push_back(stopbit);
            ef = !stopbit;
        end
        bus.i_exist_oddcheck  = odd;
        bus.i_exist_evencheck = even;
        bus.i_exist_stop      = stp;
        bus.i_bitnum          = 4'(nb);
        @(negedge clk);
        k = cyc;
        if (cut >= bits.size()) begin
            e_data.push_back(ed);
            e_perr.push_back(ep);
            e_ferr.push_back(ef);
            e_cyc.push_back(k + SYNC_STAGES_DEF + 1 + OS * (bits.size() - 1) + OS / 2 + 1);
        end
        for (int i = 0; i < bits.size() && i < cut; i++) begin
            bus.i_rx = bits[i];
            repeat (OS) @(negedge clk);
            if (i == 0) begin
                // Config changes after the start edge must be ignored.
                bus.i_exist_oddcheck  = 1'($urandom);
                bus.i_exist_evencheck = 1'($urandom);
                bus.i_exist_stop      = 1'($urandom);
                bus.i_bitnum          = 4'($urandom);
            end
        end
        bus.i_rx = 1'b1;
    endtask

    task automatic expect_all(input string tag);
        int w;
        w = 0;
        while (q_data.size() < e_data.size() && w < 64) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_count"}, 32'(q_data.size()), 32'(e_data.size()));
        while (q_data.size() > 0 && e_data.size() > 0) begin
            check({tag, "_data"}, 32'(q_data.pop_front()), 32'(e_data.pop_front()));
            check({tag, "_perr"}, 32'(q_perr.pop_front()), 32'(e_perr.pop_front()));
            check({tag, "_ferr"}, 32'(q_ferr.pop_front()), 32'(e_ferr.pop_front()));
            check({tag, "_cycle"}, 32'(q_cyc.pop_front()), 32'(e_cyc.pop_front()));
            check({tag, "_busy_at_strobe"}, 32'(q_busy.pop_front()), 32'(0));
        end
        q_data.delete(); q_perr.delete(); q_ferr.delete(); q_busy.delete(); q_cyc.delete();
        e_data.delete(); e_perr.delete(); e_ferr.delete(); e_cyc.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"},  32'(bus.o_data), 32'(0));
        check({tag, "_valid"}, 32'(bus.o_data_valid), 32'(0));
        check({tag, "_perr"},  32'(bus.o_parity_err), 32'(0));
        check({tag, "_ferr"},  32'(bus.o_frame_err), 32'(0));
        check({tag, "_busy"},  32'(bus.o_busy), 32'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_rx              = 1'b1;
        bus.i_exist_oddcheck  = 1'b0;
        bus.i_exist_evencheck = 1'b0;
        bus.i_exist_stop      = 1'b1;
        bus.i_bitnum          = 4'd8;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // 8 bits, odd parity, stop
        busy_seen = 1'b0;
        send(8'h55, 8, 1, 0, 1, 0, 1, 99);
        check("t1_busy_mid_frame", 32'(busy_seen), 32'(1));
        expect_all("t1_8O1_55");
        repeat (4) @(negedge clk);

        // 5 bits, even parity: clean, then flipped parity bit
        send(8'h1F, 5, 0, 1, 1, 0, 1, 99);
        expect_all("t2_5E1_1F");
        repeat (4) @(negedge clk);
        send(8'h1F, 5, 0, 1, 1, 1, 1, 99);
        expect_all("t2_5E1_1F_flip");
        repeat (4) @(negedge clk);

        // 8N1 with a broken stop bit
        send(8'hA3, 8, 0, 0, 1, 0, 0, 99);
        expect_all("t3_8N1_A3_ferr");
        repeat (4) @(negedge clk);

        // Short low glitch on the idle line
        busy_seen = 1'b0;
        bus.i_rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_glitch_busy", 32'(busy_seen), 32'(0));
        expect_all("t4_glitch");

        // Back-to-back frames
        send(8'h00, 8, 0, 0, 1, 0, 1, 99);
        send(8'hFF, 8, 0, 0, 1, 0, 1, 99);
        expect_all("t5_b2b");
        repeat (4) @(negedge clk);

        // Reset in the middle of the data bits
        send(8'h5A, 8, 0, 0, 1, 0, 1, 4);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("t6_rst_mid");
        rst = 1'b0;
        repeat (200) @(negedge clk);
        expect_all("t6_abandoned");
        send(8'h3C, 8, 0, 0, 1, 0, 1, 99);
        expect_all("t6_after_rst_3C");
        repeat (4) @(negedge clk);

        // Width clamping, odd-over-even priority, no stop and no parity
        send(8'hFF, 0, 0, 0, 1, 0, 1, 99);
        expect_all("clamp_lo");
        repeat (4) @(negedge clk);
        send(8'hC7, 15, 1, 0, 1, 0, 1, 99);
        expect_all("clamp_hi");
        repeat (4) @(negedge clk);
        send(8'h6B, 7, 1, 1, 1, 0, 1, 99);
        expect_all("odd_wins");
        repeat (4) @(negedge clk);
        send(8'h96, 8, 0, 0, 0, 0, 1, 99);
        repeat (4) @(negedge clk);
        expect_all("no_stop_no_par");
        repeat (4) @(negedge clk);

        // Random frames
        for (int r = 0; r < 24; r++) begin
            logic [7:0] d;
            int         nb;
            bit         od;
            bit         ev;
            bit         st;
            bit         fl;
            bit         sb;
            d  = 8'($urandom);
            nb = int'($urandom_range(15, 0));
            od = 1'($urandom);
            ev = 1'($urandom);
            st = 1'($urandom);
            fl = 1'($urandom);
            sb = ($urandom_range(3, 0) != 0);
            send(d, nb, od, ev, st, fl, sb, 99);
            repeat (int'($urandom_range(20, 2))) @(negedge clk);
            expect_all($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
